// File: rtl/grip_actuator_pkg.sv
// grip_actuator_pkg: shared FSM encoding, default timing constants and parameter legality check for the grip servo driver.
package grip_actuator_pkg;
  typedef enum logic {HOLD = 1'b0, RAMP = 1'b1} state_t;
  localparam int DEF_FRAME_CYC = 1_000_000;
  localparam int DEF_PW_OPEN   = 50_000;
  localparam int DEF_PW_CLOSE  = 100_000;
  localparam int DEF_RAMP_STEP = 2_500;
  localparam int DEF_N_CONFIRM = 2;
  localparam int CONF_W        = 4;
  function automatic bit cfg_legal(input int frame_cyc, input int pw_open, input int pw_close,
                                   input int ramp_step, input int n_confirm);
    return pw_open > 0 && pw_open < pw_close && pw_close < frame_cyc && ramp_step > 0 &&
           n_confirm >= 1 && n_confirm <= 15;
  endfunction
endpackage

// File: rtl/grip_actuator_pwm_frame_gen.sv
// pwm_frame_gen: free-running servo frame counter with registered width compare and a wrap strobe on the last cycle.
module pwm_frame_gen
  import grip_actuator_pkg::*;
#(
  parameter int FRAME_CYC = DEF_FRAME_CYC,
  parameter int W         = $clog2(FRAME_CYC)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pw,
  output logic         pwm,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(FRAME_CYC - 1);
  logic [W-1:0] frame_cnt;
  assign wrap = frame_cnt == LAST;
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      pwm       <= 1'b0;
    end else begin
      frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      pwm       <= frame_cnt < pw;
    end
  end
endmodule

// File: rtl/grip_actuator.sv
// grip_actuator: confirms EMG grip decisions and drives the hand servo PWM; GRIP_RAMP_EN selects stepped ramping.
module grip_actuator
  import grip_actuator_pkg::*;
#(
  parameter int FRAME_CYC = DEF_FRAME_CYC,
  parameter int PW_OPEN   = DEF_PW_OPEN,
  parameter int PW_CLOSE  = DEF_PW_CLOSE,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int N_CONFIRM = DEF_N_CONFIRM
) (
  input  logic clk,
  input  logic reset,
  input  logic wr,
  input  logic ctrl,
  output logic pwm,
  output logic grip,
  output logic moving
);
  localparam int W = $clog2(FRAME_CYC);
  localparam logic [W-1:0] PWO = W'(PW_OPEN);
  localparam logic [W-1:0] PWC = W'(PW_CLOSE);
  localparam logic [CONF_W-1:0] NC = CONF_W'(N_CONFIRM);
  if (!cfg_legal(FRAME_CYC, PW_OPEN, PW_CLOSE, RAMP_STEP, N_CONFIRM)) begin : g_illegal
    $error("grip_actuator: illegal timing parameters");
  end
  state_t state, state_nxt;
  logic [W-1:0] pw_cur, pw_nxt, tgt;
  logic [CONF_W-1:0] conf_cnt, cnt_nxt;
  logic pend, wrap;
  pwm_frame_gen #(.FRAME_CYC(FRAME_CYC), .W(W)) u_frame (
    .clk  (clk),
    .reset(reset),
    .pw   (pw_cur),
    .pwm  (pwm),
    .wrap (wrap)
  );
  assign tgt = grip ? PWC : PWO;
  // a decision only becomes the grip once N_CONFIRM equal strobes arrive in a row
  always_comb cnt_nxt = (ctrl != pend) ? CONF_W'(1) : (conf_cnt == NC) ? NC : conf_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= 1'b0;
      conf_cnt <= '0;
      grip     <= 1'b0;
    end else if (wr) begin
      pend     <= ctrl;
      conf_cnt <= cnt_nxt;
      if (cnt_nxt == NC && ctrl != grip) grip <= ctrl;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= HOLD;
      pw_cur <= PWO;
    end else begin
      state  <= state_nxt;
      if (wrap) pw_cur <= pw_nxt;
    end
  end
  always_comb state_nxt = wrap ? ((pw_nxt == tgt) ? HOLD : RAMP) : state;
`ifdef GRIP_RAMP_EN
  localparam int STEP_SAT = RAMP_STEP < FRAME_CYC ? RAMP_STEP : FRAME_CYC;
  localparam logic [W:0] STEP = (W + 1)'(STEP_SAT);
  logic [W:0] cur_x, tgt_x;
  // one extra bit keeps cur+STEP and tgt+STEP from wrapping before the clamp
  always_comb begin
    cur_x  = {1'b0, pw_cur};
    tgt_x  = {1'b0, tgt};
    moving = pw_cur != tgt;
    pw_nxt = W'(tgt_x > cur_x ? ((cur_x + STEP > tgt_x) ? tgt_x : cur_x + STEP)
                              : ((cur_x > tgt_x + STEP) ? cur_x - STEP : tgt_x));
  end
`else
  always_comb begin
    moving = pw_cur != tgt;
    pw_nxt = tgt;
  end
`endif
endmodule
